// File: rtl/regbank_write_arbiter.sv
// Round-robin write arbiter feeding one shared register bank: zero-latency ack,
// registered one-hot enable/data, and a bounded lock for back-to-back writes.
module regbank_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int NREG     = 8,
  parameter int W        = 32,
  parameter int AW       = $clog2(NREG),
  parameter int LOCK_MAX = 4,
  localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int LW      = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NREQ-1:0]     i_req,
  input  logic [NREQ*AW-1:0]  i_req_addr,
  input  logic [NREQ*W-1:0]   i_req_data,
  input  logic [NREQ-1:0]     i_lock,
  output logic [NREQ-1:0]     o_ack,
  output logic [NREG-1:0]     o_e,
  output logic [W-1:0]        o_d,
  output logic [GW-1:0]       o_grant_id,
  output logic                o_err
);

  localparam logic [NREG-1:0] NREG_ONE = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [NREQ-1:0] NREQ_ONE = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [AW:0]     NREG_LIM = NREG[AW:0];

  logic [GW-1:0]   r_ptr;
  logic [LW-1:0]   r_lcnt;
  logic [NREG-1:0] r_e;
  logic [W-1:0]    r_d;
  logic [GW-1:0]   r_gid;
  logic            r_err;

  logic            w_found;
  logic [GW-1:0]   w_win;
  logic [AW-1:0]   w_addr;
  logic [W-1:0]    w_data;
  logic            w_in_range;
  logic [NREG-1:0] w_onehot;
  logic [GW-1:0]   w_ptr_nxt;
  logic [LW-1:0]   w_lcnt_nxt;

  // Scan from ptr downward in priority so the last hit is the first requester after ptr.
  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      v_idx   = (int'(r_ptr) + k) % NREQ;
      w_win   = i_req[v_idx] ? GW'(v_idx) : w_win;
      w_found = w_found | i_req[v_idx];
    end
  end

  assign w_addr     = i_req_addr[int'(w_win)*AW +: AW];
  assign w_data     = i_req_data[int'(w_win)*W +: W];
  assign w_in_range = ({1'b0, w_addr} < NREG_LIM);
  assign w_onehot   = NREG_ONE << w_addr;

  // Acknowledge the winner; suppressed while reset is held.
  always_comb begin
    o_ack = '0;
    if (w_found && i_rst_n) begin
      o_ack = NREQ_ONE << w_win;
    end else begin
      o_ack = '0;
    end
  end

  // A locked winner keeps priority until it has taken LOCK_MAX grants in a row.
  always_comb begin
    w_ptr_nxt  = r_ptr;
    w_lcnt_nxt = '0;
    if (w_found) begin
      if (i_lock[w_win] && ((int'(r_lcnt) + 1) < LOCK_MAX)) begin
        w_ptr_nxt  = w_win;
        w_lcnt_nxt = r_lcnt + LW'(1);
      end else begin
        w_ptr_nxt  = (int'(w_win) == NREQ - 1) ? GW'(0) : (w_win + GW'(1));
        w_lcnt_nxt = '0;
      end
    end else begin
      w_ptr_nxt  = r_ptr;
      w_lcnt_nxt = '0;
    end
  end

  // Arbiter state and bank-facing output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr  <= '0;
      r_lcnt <= '0;
      r_e    <= '0;
      r_d    <= '0;
      r_gid  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_ptr  <= w_ptr_nxt;
      r_lcnt <= w_lcnt_nxt;
      if (w_found) begin
        r_e   <= w_in_range ? w_onehot : '0;
        r_err <= ~w_in_range;
        r_d   <= w_data;
        r_gid <= w_win;
      end else begin
        r_e   <= '0;
        r_err <= 1'b0;
      end
    end
  end

  assign o_e        = r_e;
  assign o_d        = r_d;
  assign o_grant_id = r_gid;
  assign o_err      = r_err;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter: reset, rotation, lock bound,
// out-of-range address (NREG=6 instance), mid-stream reset and idle gaps.
module tb_regbank_write_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req, lock;
  logic [11:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   ack;
  logic [7:0]   e;
  logic [31:0]  d;
  logic [1:0]   gid;
  logic         err;

  logic [3:0]   req6, lock6;
  logic [11:0]  req_addr6;
  logic [127:0] req_data6;
  logic [3:0]   ack6;
  logic [5:0]   e6;
  logic [31:0]  d6;
  logic [1:0]   gid6;
  logic         err6;

  int n_chk = 0;
  int n_err = 0;

  logic [2:0]  a  [4];
  logic [31:0] dv [4];
  logic [31:0] last_d;
  int lock_exp [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};

  regbank_write_arbiter u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_addr(req_addr),
    .i_req_data(req_data), .i_lock(lock), .o_ack(ack), .o_e(e), .o_d(d),
    .o_grant_id(gid), .o_err(err)
  );

  regbank_write_arbiter #(.NREG(6)) u_dut6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req6), .i_req_addr(req_addr6),
    .i_req_data(req_data6), .i_lock(lock6), .o_ack(ack6), .o_e(e6), .o_d(d6),
    .o_grant_id(gid6), .o_err(err6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; lock = '0; req6 = '0; lock6 = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; req_addr = '0; req_data = '0;
    req6 = '0; lock6 = '0; req_addr6 = '0; req_data6 = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = 3'(i + 1);
      dv[i] = 32'h1111_0000 + 32'(i);
    end

    // Reset held two cycles; ack forced low even with requests pending
    @(negedge clk);
    #1;
    chk("reset_e", e, 8'h00);
    chk("reset_d", d, 32'h0);
    chk("reset_gid", gid, 2'd0);
    chk("reset_err", err, 1'b0);
    req = 4'b1111;
    #1;
    chk("reset_ack", ack, 4'b0000);

    // Single write from requester 2
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0100;
    req_addr[6 +: 3] = 3'd5;
    req_data[64 +: 32] = 32'hDEADBEEF;
    #1;
    chk("single_ack", ack, 4'b0100);
    chk("single_e_pre", e, 8'h00);
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("single_e", e, 8'b0010_0000);
    chk("single_d", d, 32'hDEADBEEF);
    chk("single_gid", gid, 2'd2);
    chk("single_ack_idle", ack, 4'b0000);
    @(negedge clk);
    #1;
    chk("single_e_off", e, 8'h00);
    chk("single_d_hold", d, 32'hDEADBEEF);

    // Round robin with all four requesting
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_addr[i*3 +: 3] = a[i];
      req_data[i*32 +: 32] = dv[i];
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req = 4'b1111;
      #1;
      chk("rr_ack", ack, 64'd1 << (k % 4));
      if (k > 0) begin
        chk("rr_e", e, 64'd1 << a[(k-1) % 4]);
        chk("rr_d", d, dv[(k-1) % 4]);
        chk("rr_gid", gid, 64'((k-1) % 4));
      end
    end
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("rr_e_last", e, 64'd1 << a[3]);
    chk("rr_d_last", d, dv[3]);
    chk("rr_gid_last", gid, 2'd3);
    chk("rr_ack_idle", ack, 4'b0000);

    // Lock bound: requester 0 locked against requester 1
    do_reset();
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      req = 4'b0011;
      lock = 4'b0001;
      #1;
      chk("lock_ack", ack, 64'd1 << lock_exp[k]);
    end
    @(negedge clk);
    req = 4'b0000;
    lock = 4'b0000;

    // Out-of-range address on the six-register instance
    do_reset();
    req_addr6[3 +: 3] = 3'd7;
    req_data6[32 +: 32] = 32'h5555AAAA;
    req_addr6[6 +: 3] = 3'd3;
    req_data6[64 +: 32] = 32'h2222_3333;
    @(negedge clk);
    req6 = 4'b0010;
    #1;
    chk("oor_ack", ack6, 4'b0010);
    @(negedge clk);
    req6 = 4'b1111;
    #1;
    chk("oor_e", e6, 6'b000000);
    chk("oor_err", err6, 1'b1);
    chk("oor_gid", gid6, 2'd1);
    chk("oor_d", d6, 32'h5555AAAA);
    chk("oor_ptr_adv", ack6, 4'b0100);
    @(negedge clk);
    req6 = 4'b0000;
    #1;
    chk("oor_err_off", err6, 1'b0);
    chk("oor_e_next", e6, 6'b001000);
    chk("oor_gid_next", gid6, 2'd2);

    // Reset asserted for one edge in the middle of a stream
    @(negedge clk);
    req = 4'b1111;
    #1;
    chk("mid_ack_pre", ack, 4'b0001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_ack_rst", ack, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_e", e, 8'h00);
    chk("mid_d", d, 32'h0);
    chk("mid_err", err, 1'b0);
    chk("mid_gid", gid, 2'd0);
    chk("mid_ack_post", ack, 4'b0001);

    // Idle gaps: requester 3 pulses on odd cycles only
    req_addr[9 +: 3] = 3'd6;
    last_d = dv[0];
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      req = (c % 2 == 1 && c < 7) ? 4'b1000 : 4'b0000;
      req_data[96 +: 32] = 32'hC0DE_0000 + 32'(c);
      #1;
      chk("idle_ack", ack, (c % 2 == 1 && c < 7) ? 64'h8 : 64'h0);
      if (c == 1) begin
        chk("idle_e", e, 64'd1 << a[0]);
      end else begin
        chk("idle_e", e, ((c - 1) % 2 == 1) ? 64'h40 : 64'h0);
      end
      chk("idle_d", d, last_d);
      if (c % 2 == 1 && c < 7) begin
        last_d = 32'hC0DE_0000 + 32'(c);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Round-robin write-port arbiter that shares one bank of enabled 32-bit registers (D/E/Q style, enable-gated capture) among several requesters. Each cycle it selects at most one pending write request, acknowledges it, and drives the bank's shared data bus plus a one-hot per-register enable for exactly one cycle. It sits between the datapath units (ALU writeback, load unit, debug port, and so on) and the register bank. It supports a bounded "lock" so one requester can issue back-to-back writes without starving the others.

## Interface
- NREQ, 4, number of requesters (2..8)
- NREG, 8, number of registers in the bank
- W, 32, data width
- AW, $clog2(NREG), register address width
- LOCK_MAX, 4, maximum consecutive locked grants to one requester (≥1)

- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-low reset (Reset=0 at a rising edge resets the block)
- req  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  target register of requester i in bits [i*AW +: AW]
- req_data  in  NREQ*W  write data of requester i in bits [i*W +: W]
- lock  in  NREQ  requester i asks to keep priority after its grant
- ack  out  NREQ  one-hot, combinational; request accepted this cycle
- E  out  NREG  registered one-hot register enable to the bank
- D  out  W  registered shared write data to the bank
- grant_id  out  $clog2(NREQ)  registered index of the requester whose write is on E/D
- err  out  1  registered; one-cycle pulse when an accepted write targeted addr ≥ NREG

## Operation
- State: round-robin pointer ptr (0..NREQ-1), lock counter lcnt (0..LOCK_MAX), output registers E/D/grant_id/err.
- Arbitration (combinational, cycle t): winner = first i with req[i]=1, scanning ptr, ptr+1, …, wrapping modulo NREQ. ack[winner]=1, all other acks 0. No req → ack=0.
- ack is forced to 0 while Reset=0.
- Accept (edge ending cycle t, winner exists):
  - E ← onehot(req_addr[winner]) if addr < NREG, else 0 and err ← 1.
  - D ← req_data[winner]; grant_id ← winner.
- No winner: E ← 0, err ← 0. D and grant_id hold.
- Pointer update on accept:
  - lock[winner]=1 and lcnt+1 < LOCK_MAX: ptr ← winner, lcnt ← lcnt+1.
  - Otherwise: ptr ← (winner+1) mod NREQ, lcnt ← 0.
- Pointer update with no winner: ptr holds, lcnt ← 0.
- A requester holding req high after seeing ack is making a new request. Each ack equals exactly one write.
- Lock only grants priority. A locked requester that drops req loses it; the next winner is scanned from ptr as usual.
- Reset (Reset=0 at an edge): ptr=0, lcnt=0, E=0, D=0, grant_id=0, err=0. A write accepted in the same cycle as reset is discarded and is not re-issued.

## Timing
- Request at cycle t with ack in cycle t (zero-latency ack).
- E/D asserted during cycle t+1 for exactly one cycle per accepted write.
- Bank Q shows the new value from cycle t+2.
- Throughput: one write per cycle sustained. E is never asserted for more than one register at a time.
- Back-to-back writes to the same register from different requesters both occur in grant order. The later write wins in Q.
- Fairness bound: a continuously requesting requester is acked within (NREQ-1)·LOCK_MAX + 1 cycles.

## Test plan
- Reset then single write: Reset=0 for 2 cycles, then req[2]=1, addr=5, data=32'hDEADBEEF for one cycle. Required: ack=4'b0100 that cycle; next cycle E=8'b0010_0000, D=32'hDEADBEEF, grant_id=2; following cycle E=0. All outputs 0 while in reset.
- Round-robin rotation: req=4'b1111 held for 8 cycles, no lock. Required: ack sequence 0001, 0010, 0100, 1000, 0001, …; E/D trail by one cycle with each requester's addr/data.
- Lock bound with LOCK_MAX=4: req=4'b0011 held, lock[0]=1. Required: ack[0] for 4 consecutive cycles, then ack[1] once, then ack[0] for 4 cycles again.
- Out-of-range address with NREG=6: req[1], addr=7. Required: ack[1]=1; next cycle E=0, err=1 for one cycle, grant_id=1; ptr advances to 2.
- Reset mid-stream: req=4'b1111 streaming, Reset=0 asserted for one edge. Required: ack=0 during that cycle; after the edge E=0, D=0, err=0, ptr=0, so the next ack goes to requester 0.
- Idle gaps: req pulses only on odd cycles from requester 3. Required: E nonzero only on the cycle after each pulse; D holds its last value through idle cycles.
